bcd_to_binary: RTL

Sequential BCD-to-binary converter, the inverse of the score/timer binary-to-BCD path. It accepts a three-digit BCD value (hundreds 0–2, tens 0–9, ones 0–9) and returns the 8-bit binary equivalent using an iterative reverse double-dabble. It sits between the digit-entry/settings logic (BCD digits edited by the player) and the game core (binary counters and thresholds). Out-of-range input is flagged instead of converted.

---
 rtl/bcd_to_binary_if.sv | 27 ++
 rtl/bcd_to_binary.sv | 99 +++++++++
 2 files changed

// File: rtl/bcd_to_binary_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_if : request/result bundle for the BCD-to-binary converter, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bcd_to_binary_if;
  logic       start;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, hundreds, tens, ones,
    input  bin, busy, done, err
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output bin, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary : iterative reverse double-dabble, 3-digit BCD to 8-bit binary, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_binary (
  input  logic            clk,
  input  logic            reset,
  bcd_to_binary_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] bcd;
  logic [7:0]  sh;
  logic [2:0]  count;

  logic        in_range;
  logic [11:0] bcd_shift;
  logic [11:0] bcd_next;
  logic [7:0]  sh_next;

  function automatic logic [3:0] fix3(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  always_comb begin
    // Anything above 255 cannot be represented in the 8-bit result.
    in_range = (bus.tens <= 4'd9) && (bus.ones <= 4'd9) && (bus.hundreds != 2'd3) &&
               !((bus.hundreds == 2'd2) &&
                 ((bus.tens > 4'd5) || ((bus.tens == 4'd5) && (bus.ones > 4'd5))));
    bcd_shift = {1'b0, bcd[11:1]};
    sh_next   = {bcd[0], sh[7:1]};
    bcd_next  = {fix3(bcd_shift[11:8]), fix3(bcd_shift[7:4]), fix3(bcd_shift[3:0])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bcd      <= 12'h000;
      sh       <= 8'h00;
      count    <= 3'd0;
      bus.bin  <= 8'h00;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (in_range) begin
              bcd     <= {2'b00, bus.hundreds, bus.tens, bus.ones};
              sh      <= 8'h00;
              count   <= 3'd0;
              bus.err <= 1'b0;
              state   <= CONV;
            end else begin
              bus.bin  <= 8'h00;
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        CONV: begin
          bcd <= bcd_next;
          sh  <= sh_next;
          if (count == 3'd7) begin
            bus.bin  <= sh_next;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count + 3'd1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
